// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared D-cache flush types: walk states and line-address builder.
package ariane_pkg;

  typedef enum logic [2:0] {
    FLUSH_IDLE      = 3'd0,
    FLUSH_READ      = 3'd1,
    FLUSH_CHECK     = 3'd2,
    FLUSH_WRITEBACK = 3'd3,
    FLUSH_INVAL     = 3'd4,
    FLUSH_ACK       = 3'd5
  } dcache_flush_state_e;

  // Tags up to 64 bits and sets up to 32 bits; callers truncate to their own address width.
  localparam int unsigned DCACHE_FLUSH_MAX_ADDR = 128;

  function automatic logic [DCACHE_FLUSH_MAX_ADDR-1:0] dcache_flush_line_addr(
    input logic [63:0] tag,
    input logic [31:0] set,
    input int unsigned set_bits,
    input int unsigned offset_bits
  );
    logic [DCACHE_FLUSH_MAX_ADDR-1:0] addr;
    addr = ({64'b0, tag} << (set_bits + offset_bits)) | ({96'b0, set} << offset_bits);
    return addr;
  endfunction

endpackage

// File: rtl/dcache_flush_unit.sv
// rtl/dcache_flush_unit.sv - D-cache flush walker: reads every set/way, writes back dirty lines, invalidates valid ones.
// Write-back handling is built only when DCACHE_FLUSH_WB_EN is defined; otherwise the cache is treated as write-through.
module dcache_flush_unit
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 256,
  parameter int unsigned NUM_WAYS    = 8,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned TAG_WIDTH   = 44,
  localparam int unsigned SET_BITS    = $clog2(NUM_SETS),
  localparam int unsigned WAY_BITS    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8),
  localparam int unsigned ADDR_WIDTH  = TAG_WIDTH + SET_BITS + OFFSET_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  output logic                  flush_ack_o,
  output logic                  busy_o,
  output logic                  rd_req_o,
  input  logic                  rd_gnt_i,
  output logic [SET_BITS-1:0]   rd_set_o,
  output logic [WAY_BITS-1:0]   rd_way_o,
  input  logic                  rd_valid_i,
  input  logic                  rd_dirty_i,
  input  logic [TAG_WIDTH-1:0]  rd_tag_i,
  input  logic [LINE_WIDTH-1:0] rd_data_i,
  output logic                  inv_req_o,
  input  logic                  inv_gnt_i,
  output logic [SET_BITS-1:0]   inv_set_o,
  output logic [WAY_BITS-1:0]   inv_way_o,
  output logic                  wb_req_o,
  input  logic                  wb_gnt_i,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [LINE_WIDTH-1:0] wb_data_o
);

  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);
  localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(NUM_WAYS - 1);

  dcache_flush_state_e state_q, state_d;
  logic [SET_BITS-1:0] set_q, set_d;
  logic [WAY_BITS-1:0] way_q, way_d;
  logic                advance;
  logic                last_line;

  // Way is the inner loop; the walk ends after the last way of the last set.
  assign last_line = (set_q == LAST_SET) && (way_q == LAST_WAY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FLUSH_IDLE;
      set_q   <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
    end
  end

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    advance = 1'b0;

    unique case (state_q)
      FLUSH_IDLE: begin
        if (flush_i) begin
          state_d = FLUSH_READ;
          set_d   = '0;
          way_d   = '0;
        end
      end
      FLUSH_READ: begin
        if (rd_gnt_i) state_d = FLUSH_CHECK;
      end
      FLUSH_CHECK: begin
        if (rd_valid_i) begin
`ifdef DCACHE_FLUSH_WB_EN
          state_d = rd_dirty_i ? FLUSH_WRITEBACK : FLUSH_INVAL;
`else
          state_d = FLUSH_INVAL;
`endif
        end else begin
          advance = 1'b1;
        end
      end
`ifdef DCACHE_FLUSH_WB_EN
      FLUSH_WRITEBACK: begin
        if (wb_gnt_i) state_d = FLUSH_INVAL;
      end
`endif
      FLUSH_INVAL: begin
        if (inv_gnt_i) advance = 1'b1;
      end
      FLUSH_ACK: begin
        state_d = FLUSH_IDLE;
      end
      default: begin
        state_d = FLUSH_IDLE;
      end
    endcase

    if (advance) begin
      if (last_line) begin
        state_d = FLUSH_ACK;
        set_d   = '0;
        way_d   = '0;
      end else begin
        state_d = FLUSH_READ;
        if (way_q == LAST_WAY) begin
          way_d = '0;
          set_d = set_q + 1'b1;
        end else begin
          way_d = way_q + 1'b1;
        end
      end
    end
  end

  assign flush_ack_o = (state_q == FLUSH_ACK);
  assign busy_o      = (state_q != FLUSH_IDLE);
  assign rd_req_o    = (state_q == FLUSH_READ);
  assign rd_set_o    = set_q;
  assign rd_way_o    = way_q;
  assign inv_req_o   = (state_q == FLUSH_INVAL);
  assign inv_set_o   = set_q;
  assign inv_way_o   = way_q;

`ifdef DCACHE_FLUSH_WB_EN
  logic [ADDR_WIDTH-1:0] wb_addr_q;
  logic [LINE_WIDTH-1:0] wb_data_q;

  // Captured on every CHECK so the writeback payload stays stable across grant stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else if (state_q == FLUSH_CHECK) begin
      wb_addr_q <= ADDR_WIDTH'(dcache_flush_line_addr(64'(rd_tag_i), 32'(set_q),
                                                      SET_BITS, OFFSET_BITS));
      wb_data_q <= rd_data_i;
    end
  end

  assign wb_req_o  = (state_q == FLUSH_WRITEBACK);
  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;
`else
  logic unused_wt_inputs;
  assign unused_wt_inputs = ^{rd_dirty_i, rd_tag_i, rd_data_i, wb_gnt_i};

  assign wb_req_o  = 1'b0;
  assign wb_addr_o = '0;
  assign wb_data_o = '0;
`endif

endmodule

// File: tb/tb_dcache_flush_unit.sv
// tb/tb_dcache_flush_unit.sv - self-checking bench for dcache_flush_unit against a line-list reference model.
module tb_dcache_flush_unit;

  localparam int NS = 4;
  localparam int NW = 2;
  localparam int LW = 128;
  localparam int TW = 44;
  localparam int SB = 2;
  localparam int WBITS = 1;
  localparam int AW = 50;
`ifdef DCACHE_FLUSH_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic            clk;
  logic            rst_i;
  logic            flush_i;
  logic            flush_ack_o;
  logic            busy_o;
  logic            rd_req_o;
  logic            rd_gnt_i;
  logic [SB-1:0]   rd_set_o;
  logic [WBITS-1:0] rd_way_o;
  logic            rd_valid_i;
  logic            rd_dirty_i;
  logic [TW-1:0]   rd_tag_i;
  logic [LW-1:0]   rd_data_i;
  logic            inv_req_o;
  logic            inv_gnt_i;
  logic [SB-1:0]   inv_set_o;
  logic [WBITS-1:0] inv_way_o;
  logic            wb_req_o;
  logic            wb_gnt_i;
  logic [AW-1:0]   wb_addr_o;
  logic [LW-1:0]   wb_data_o;

  dcache_flush_unit #(
    .NUM_SETS(NS), .NUM_WAYS(NW), .LINE_WIDTH(LW), .TAG_WIDTH(TW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .flush_ack_o(flush_ack_o), .busy_o(busy_o),
    .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_set_o(rd_set_o), .rd_way_o(rd_way_o),
    .rd_valid_i(rd_valid_i), .rd_dirty_i(rd_dirty_i), .rd_tag_i(rd_tag_i), .rd_data_i(rd_data_i),
    .inv_req_o(inv_req_o), .inv_gnt_i(inv_gnt_i), .inv_set_o(inv_set_o), .inv_way_o(inv_way_o),
    .wb_req_o(wb_req_o), .wb_gnt_i(wb_gnt_i), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit            mv  [NS][NW];
  bit            md  [NS][NW];
  logic [TW-1:0] mt  [NS][NW];
  logic [LW-1:0] mdat[NS][NW];

  int            exp_rd_set[$], exp_rd_way[$], exp_inv_set[$], exp_inv_way[$];
  logic [AW-1:0] exp_wb_addr[$];
  logic [LW-1:0] exp_wb_data[$];
  int            exp_cycles;

  int            obs_rd_set[$], obs_rd_way[$], obs_inv_set[$], obs_inv_way[$];
  logic [AW-1:0] obs_wb_addr[$];
  logic [LW-1:0] obs_wb_data[$];
  int            obs_ack_cycle, obs_ack_count, obs_stalls, obs_conflicts, obs_unstable;
  int            obs_busy_gap, obs_post_busy;
  bit            obs_timeout;

  function automatic void model_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 1'b0; md[s][w] = 1'b0; mt[s][w] = '0; mdat[s][w] = '0;
      end
  endfunction

  function automatic void model_randomize();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        mv[s][w]   = 1'($urandom());
        md[s][w]   = 1'($urandom());
        mt[s][w]   = TW'({$urandom(), $urandom()});
        mdat[s][w] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
  endfunction

  // Every line is read in set-major order; valid lines are invalidated, dirty ones written back first.
  function automatic void model_expect();
    exp_rd_set.delete(); exp_rd_way.delete(); exp_inv_set.delete(); exp_inv_way.delete();
    exp_wb_addr.delete(); exp_wb_data.delete();
    exp_cycles = 1;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        exp_rd_set.push_back(s); exp_rd_way.push_back(w);
        if (mv[s][w]) begin
          exp_inv_set.push_back(s); exp_inv_way.push_back(w);
          if (WB_EN && md[s][w]) begin
            exp_wb_addr.push_back((AW'(mt[s][w]) << 6) | (AW'(s) << 4));
            exp_wb_data.push_back(mdat[s][w]);
            exp_cycles += 4;
          end else begin
            exp_cycles += 3;
          end
        end else begin
          exp_cycles += 2;
        end
      end
  endfunction

  task automatic drive_junk();
    rd_valid_i = 1'($urandom());
    rd_dirty_i = 1'($urandom());
    rd_tag_i   = TW'({$urandom(), $urandom()});
    rd_data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Acts as requester and array: raises flush_i, answers requests and records what the DUT did.
  task automatic drive_walk(input int stall_pct, input int wb_hold, input int drop_at);
    int cycle, ps, pw, wb_held;
    bit pend, wb_prev_stall;
    logic [AW-1:0] wa;
    logic [LW-1:0] wd;
    obs_rd_set.delete(); obs_rd_way.delete(); obs_inv_set.delete(); obs_inv_way.delete();
    obs_wb_addr.delete(); obs_wb_data.delete();
    obs_ack_cycle = -1; obs_ack_count = 0; obs_stalls = 0; obs_conflicts = 0;
    obs_unstable = 0; obs_busy_gap = 0; obs_post_busy = 0; obs_timeout = 1'b0;
    pend = 1'b0; wb_prev_stall = 1'b0; wb_held = 0; ps = 0; pw = 0; wa = '0; wd = '0;
    flush_i = 1'b1;
    cycle = 0;
    while (obs_ack_cycle < 0) begin
      @(negedge clk);
      cycle++;
      if (cycle > 3000) begin obs_timeout = 1'b1; break; end
      if (cycle == drop_at) flush_i = 1'b0;
      if (pend) begin
        rd_valid_i = mv[ps][pw]; rd_dirty_i = md[ps][pw];
        rd_tag_i = mt[ps][pw]; rd_data_i = mdat[ps][pw];
        pend = 1'b0;
      end else begin
        drive_junk();
      end
      if (32'(rd_req_o) + 32'(inv_req_o) + 32'(wb_req_o) > 1) obs_conflicts++;
      if (!busy_o) obs_busy_gap++;
      rd_gnt_i = 1'b1; inv_gnt_i = 1'b1; wb_gnt_i = 1'b1;
      if (rd_req_o) begin
        if (int'($urandom_range(0, 99)) < stall_pct) begin
          rd_gnt_i = 1'b0; obs_stalls++;
        end else begin
          ps = 32'(rd_set_o); pw = 32'(rd_way_o); pend = 1'b1;
          obs_rd_set.push_back(ps); obs_rd_way.push_back(pw);
        end
      end
      if (inv_req_o) begin
        if (int'($urandom_range(0, 99)) < stall_pct) begin
          inv_gnt_i = 1'b0; obs_stalls++;
        end else begin
          obs_inv_set.push_back(32'(inv_set_o)); obs_inv_way.push_back(32'(inv_way_o));
        end
      end
      if (wb_req_o) begin
        if (wb_prev_stall && (wb_addr_o !== wa || wb_data_o !== wd)) obs_unstable++;
        wa = wb_addr_o; wd = wb_data_o;
        if (wb_held < wb_hold || int'($urandom_range(0, 99)) < stall_pct) begin
          wb_gnt_i = 1'b0; wb_held++; obs_stalls++; wb_prev_stall = 1'b1;
        end else begin
          obs_wb_addr.push_back(wb_addr_o); obs_wb_data.push_back(wb_data_o);
          wb_prev_stall = 1'b0; wb_held = 0;
        end
      end
      if (flush_ack_o) begin
        obs_ack_cycle = cycle; obs_ack_count = 1; flush_i = 1'b0;
      end
    end
    repeat (2) begin
      @(negedge clk);
      drive_junk();
      if (flush_ack_o) obs_ack_count++;
      if (busy_o) obs_post_busy++;
    end
  endtask

  task automatic test_reset();
    flush_i = 1'b0; rd_gnt_i = 1'b0; inv_gnt_i = 1'b0; wb_gnt_i = 1'b0;
    drive_junk();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (flush_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", flush_ack_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if ({rd_req_o, inv_req_o, wb_req_o} !== 3'b000) begin
      errors++; $display("FAIL reset_reqs got %b want 000", {rd_req_o, inv_req_o, wb_req_o}); end
    checks++; if (wb_addr_o !== '0 || wb_data_o !== '0) begin
      errors++; $display("FAIL reset_wb_payload got %h/%h want 0", wb_addr_o, wb_data_o); end
    checks++; if ({rd_set_o, rd_way_o, inv_set_o, inv_way_o} !== '0) begin
      errors++; $display("FAIL reset_index got %h want 0", {rd_set_o, rd_way_o, inv_set_o, inv_way_o}); end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_invalid();
    int bad;
    model_clear();
    for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) md[s][w] = 1'b1;
    model_expect();
    drive_walk(0, 0, 0);
    checks++; if (obs_timeout) begin errors++; $display("FAIL inv_all_timeout got timeout want ack"); end
    checks++; if (obs_ack_cycle !== 17) begin errors++; $display("FAIL inv_all_ack_cycle got %0d want 17", obs_ack_cycle); end
    checks++; if (obs_rd_set.size() !== 8) begin errors++; $display("FAIL inv_all_reads got %0d want 8", obs_rd_set.size()); end
    bad = 0;
    for (int i = 0; i < obs_rd_set.size() && i < 8; i++)
      if (obs_rd_set[i] !== i / 2 || obs_rd_way[i] !== i % 2) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL inv_all_read_order got %0d bad want 0", bad); end
    checks++; if (obs_inv_set.size() + obs_wb_addr.size() !== 0) begin
      errors++; $display("FAIL inv_all_no_inv_wb got %0d want 0", obs_inv_set.size() + obs_wb_addr.size()); end
    checks++; if (obs_ack_count !== 1 || obs_post_busy !== 0) begin
      errors++; $display("FAIL inv_all_idle got acks %0d busy %0d want 1/0", obs_ack_count, obs_post_busy); end
  endtask

  task automatic load_dirty_line();
    model_clear();
    mv[2][1] = 1'b1; md[2][1] = 1'b1; mt[2][1] = 44'h5;
    mdat[2][1] = {$urandom(), $urandom(), $urandom(), $urandom()};
    model_expect();
  endtask

  task automatic test_dirty_line();
    logic [AW-1:0] want_addr;
    want_addr = 50'h160;
    load_dirty_line();
    drive_walk(0, 0, 0);
    checks++; if (obs_ack_cycle !== (WB_EN ? 19 : 18)) begin
      errors++; $display("FAIL dirty_ack_cycle got %0d want %0d", obs_ack_cycle, WB_EN ? 19 : 18); end
    checks++; if (obs_wb_addr.size() !== (WB_EN ? 1 : 0)) begin
      errors++; $display("FAIL dirty_wb_count got %0d want %0d", obs_wb_addr.size(), WB_EN ? 1 : 0); end
    if (WB_EN && obs_wb_addr.size() == 1) begin
      checks++; if (obs_wb_addr[0] !== want_addr) begin
        errors++; $display("FAIL dirty_wb_addr got %h want %h", obs_wb_addr[0], want_addr); end
      checks++; if (obs_wb_data[0] !== mdat[2][1]) begin
        errors++; $display("FAIL dirty_wb_data got %h want %h", obs_wb_data[0], mdat[2][1]); end
    end
    checks++; if (obs_inv_set.size() !== 1 || obs_inv_set[0] !== 2 || obs_inv_way[0] !== 1) begin
      errors++; $display("FAIL dirty_inv got count %0d want one inv at 2/1", obs_inv_set.size()); end
  endtask

  task automatic test_wb_stall();
    load_dirty_line();
    drive_walk(0, 5, 0);
    checks++; if (obs_ack_cycle !== (WB_EN ? 24 : 18)) begin
      errors++; $display("FAIL stall_ack_cycle got %0d want %0d", obs_ack_cycle, WB_EN ? 24 : 18); end
    checks++; if (obs_unstable !== 0) begin errors++; $display("FAIL stall_wb_stable got %0d changes want 0", obs_unstable); end
    checks++; if (WB_EN && (obs_wb_addr.size() !== 1 || obs_wb_data[0] !== mdat[2][1])) begin
      errors++; $display("FAIL stall_wb_payload got %0d writebacks want 1 with line data", obs_wb_addr.size()); end
  endtask

  task automatic test_reset_mid_walk();
    bit found;
    model_clear();
    rd_gnt_i = 1'b1; inv_gnt_i = 1'b1; wb_gnt_i = 1'b1;
    flush_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rd_valid_i = 1'b0;
      if (rd_req_o && rd_set_o == 2'd1 && rd_way_o == 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach got not_found want cnt3 read"); end
    rst_i = 1'b1;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0 || flush_ack_o !== 1'b0 || rd_req_o !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got busy %b ack %b rd %b want 0/0/0", busy_o, flush_ack_o, rd_req_o); end
    rst_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0 || flush_ack_o !== 1'b0) begin
      errors++; $display("FAIL midrst_stay_idle got busy %b ack %b want 0/0", busy_o, flush_ack_o); end
    model_expect();
    drive_walk(0, 0, 0);
    checks++; if (obs_rd_set.size() == 0 || obs_rd_set[0] !== 0 || obs_rd_way[0] !== 0) begin
      errors++; $display("FAIL midrst_restart got %0d reads, first not 0/0 want restart at 0/0", obs_rd_set.size()); end
    checks++; if (obs_ack_cycle !== exp_cycles) begin
      errors++; $display("FAIL midrst_ack_cycle got %0d want %0d", obs_ack_cycle, exp_cycles); end
  endtask

  task automatic test_flush_drop();
    model_randomize();
    model_expect();
    drive_walk(0, 0, 4);
    checks++; if (obs_ack_cycle !== exp_cycles) begin
      errors++; $display("FAIL drop_ack_cycle got %0d want %0d", obs_ack_cycle, exp_cycles); end
    checks++; if (obs_ack_count !== 1 || obs_post_busy !== 0 || obs_busy_gap !== 0) begin
      errors++; $display("FAIL drop_single_ack got acks %0d post_busy %0d gaps %0d want 1/0/0",
                         obs_ack_count, obs_post_busy, obs_busy_gap); end
    checks++; if (obs_rd_set.size() !== NS * NW) begin
      errors++; $display("FAIL drop_reads got %0d want %0d", obs_rd_set.size(), NS * NW); end
  endtask

  task automatic test_random();
    int bad;
    for (int it = 0; it < 6; it++) begin
      model_randomize();
      model_expect();
      drive_walk(int'($urandom_range(0, 45)), 0, 0);
      checks++; if (obs_ack_cycle !== exp_cycles + obs_stalls) begin
        errors++; $display("FAIL rand%0d_ack_cycle got %0d want %0d", it, obs_ack_cycle, exp_cycles + obs_stalls); end
      bad = (obs_rd_set.size() == exp_rd_set.size()) ? 0 : 1;
      for (int i = 0; i < obs_rd_set.size() && i < exp_rd_set.size(); i++)
        if (obs_rd_set[i] !== exp_rd_set[i] || obs_rd_way[i] !== exp_rd_way[i]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL rand%0d_reads got %0d bad want 0", it, bad); end
      bad = (obs_inv_set.size() == exp_inv_set.size()) ? 0 : 1;
      for (int i = 0; i < obs_inv_set.size() && i < exp_inv_set.size(); i++)
        if (obs_inv_set[i] !== exp_inv_set[i] || obs_inv_way[i] !== exp_inv_way[i]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL rand%0d_invs got %0d bad want 0", it, bad); end
      bad = (obs_wb_addr.size() == exp_wb_addr.size()) ? 0 : 1;
      for (int i = 0; i < obs_wb_addr.size() && i < exp_wb_addr.size(); i++)
        if (obs_wb_addr[i] !== exp_wb_addr[i] || obs_wb_data[i] !== exp_wb_data[i]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL rand%0d_wbs got %0d bad want 0", it, bad); end
      checks++; if (obs_conflicts !== 0 || obs_unstable !== 0) begin
        errors++; $display("FAIL rand%0d_protocol got conflicts %0d unstable %0d want 0/0", it, obs_conflicts, obs_unstable); end
      checks++; if (obs_ack_count !== 1 || obs_post_busy !== 0) begin
        errors++; $display("FAIL rand%0d_ack_pulse got acks %0d busy %0d want 1/0", it, obs_ack_count, obs_post_busy); end
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    rd_gnt_i = 1'b0; inv_gnt_i = 1'b0; wb_gnt_i = 1'b0;
    drive_junk();
    test_reset();
    test_all_invalid();
    test_dirty_line();
    test_wb_stall();
    test_reset_mid_walk();
    test_flush_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
